// File: rtl/vend_pkg.sv
// Shared types and money constants for the vending controller.
// All money values are in nickels (1 = $0.05).
package vend_pkg;

    // Coin/bill codes from the acceptor; codes 6 and 7 are invalid.
    typedef enum logic [2:0] {
        COIN_NICKEL  = 3'd0,
        COIN_DIME    = 3'd1,
        COIN_QUARTER = 3'd2,
        COIN_FIFTY   = 3'd3,
        COIN_DOLLAR  = 3'd4,
        COIN_FIVE    = 3'd5
    } coinCodeT;

    localparam int unsigned VAL_NICKEL  = 1;
    localparam int unsigned VAL_DIME    = 2;
    localparam int unsigned VAL_QUARTER = 5;
    localparam int unsigned VAL_FIFTY   = 10;
    localparam int unsigned VAL_DOLLAR  = 20;
    localparam int unsigned VAL_FIVE    = 100;

    // Coins the change dispenser can pay out.
    typedef enum logic [1:0] {
        CHG_NICKEL  = 2'd0,
        CHG_DIME    = 2'd1,
        CHG_QUARTER = 2'd2,
        CHG_DOLLAR  = 2'd3
    } changeCoinT;

    localparam int unsigned CHG_VAL_NICKEL  = 1;
    localparam int unsigned CHG_VAL_DIME    = 2;
    localparam int unsigned CHG_VAL_QUARTER = 5;
    localparam int unsigned CHG_VAL_DOLLAR  = 20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } vendStateT;

    function automatic logic coinIsValid(input logic [2:0] code);
        return code <= 3'd5;
    endfunction

    // Value of an inserted coin; invalid codes map to 0.
    function automatic logic [6:0] coinValue(input logic [2:0] code);
        case (code)
            COIN_NICKEL:  return 7'(VAL_NICKEL);
            COIN_DIME:    return 7'(VAL_DIME);
            COIN_QUARTER: return 7'(VAL_QUARTER);
            COIN_FIFTY:   return 7'(VAL_FIFTY);
            COIN_DOLLAR:  return 7'(VAL_DOLLAR);
            COIN_FIVE:    return 7'(VAL_FIVE);
            default:      return 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_controller_if.sv
// Change-coin valid/ready channel between the controller and the dispenser driver.
interface vend_controller_if;
    logic       changeValid;
    logic [1:0] changeCoin;
    logic       changeReady;

    modport master (output changeValid, output changeCoin, input changeReady);
    modport slave  (input changeValid, input changeCoin, output changeReady);
endinterface

// File: rtl/change_dispenser.sv
// Holds the amount still owed and pays it out greedily, one coin per handshake.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int MONEY_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,       // capture loadValue as the amount owed
    input  logic [MONEY_W-1:0] loadValue,
    input  logic               start,      // begin offering coins
    output logic [MONEY_W-1:0] remaining,
    output logic               done,       // last coin handed over this cycle
    vend_controller_if.master  chg
);

    localparam logic [MONEY_W-1:0] V_NICKEL  = MONEY_W'(CHG_VAL_NICKEL);
    localparam logic [MONEY_W-1:0] V_DIME    = MONEY_W'(CHG_VAL_DIME);
    localparam logic [MONEY_W-1:0] V_QUARTER = MONEY_W'(CHG_VAL_QUARTER);
    localparam logic [MONEY_W-1:0] V_DOLLAR  = MONEY_W'(CHG_VAL_DOLLAR);

    logic               active;
    changeCoinT         coin;
    logic [MONEY_W-1:0] coinVal;
    logic               fire;

    // Largest coin not exceeding the amount owed; stable while remaining holds.
    always_comb begin
        coin    = CHG_NICKEL;
        coinVal = V_NICKEL;
        if (remaining >= V_DOLLAR) begin
            coin    = CHG_DOLLAR;
            coinVal = V_DOLLAR;
        end else if (remaining >= V_QUARTER) begin
            coin    = CHG_QUARTER;
            coinVal = V_QUARTER;
        end else if (remaining >= V_DIME) begin
            coin    = CHG_DIME;
            coinVal = V_DIME;
        end
    end

    assign fire            = active && chg.changeReady;
    assign done            = fire && (remaining == coinVal);
    assign chg.changeValid = active;
    assign chg.changeCoin  = coin;

    // Amount owed and the offer flag; reset aborts any payout in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remaining <= '0;
            active    <= 1'b0;
        end else begin
            if (load)
                remaining <= loadValue;
            else if (fire)
                remaining <= remaining - coinVal;

            if (start)
                active <= 1'b1;
            else if (done)
                active <= 1'b0;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending controller: credit accumulation, price/stock tables, vend and change FSM.
module vend_controller
    import vend_pkg::*;
#(
    parameter int NUM_SLOTS  = 9,
    parameter int MONEY_W    = 8,
    parameter int MAX_CREDIT = 100,
    parameter int STOCK_W    = 4,
    parameter int IDX_W      = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 coinValid,
    input  logic [2:0]           coinCode,
    input  logic                 selValid,
    input  logic [IDX_W-1:0]     selIdx,
    input  logic                 cancel,
    input  logic                 cfgWe,
    input  logic [IDX_W-1:0]     cfgIdx,
    input  logic [MONEY_W-1:0]   cfgPrice,
    input  logic [STOCK_W-1:0]   cfgStock,
    output logic [MONEY_W-1:0]   credit,
    output logic [MONEY_W-1:0]   dispValue,
    output logic                 dispIsPrice,
    output logic [NUM_SLOTS-1:0] canAfford,
    output logic [NUM_SLOTS-1:0] soldOut,
    output logic                 coinReject,
    output logic                 vendValid,
    output logic [IDX_W-1:0]     vendIdx,
    output logic                 busy,
    vend_controller_if.master    chg
);

    localparam logic [IDX_W:0]   SLOTS   = (IDX_W+1)'(NUM_SLOTS);
    localparam logic [MONEY_W:0] CEILING = (MONEY_W+1)'(MAX_CREDIT);

    vendStateT                              state;
    logic [NUM_SLOTS-1:0][MONEY_W-1:0]      price;
    logic [NUM_SLOTS-1:0][STOCK_W-1:0]      stock;
    logic                                   showPrice;
    logic [MONEY_W-1:0]                     shownPrice;

    logic               isIdle, selOk, cfgOk;
    logic               refundGo, vendGo, showGo, coinAccept, cfgAccept;
    logic [MONEY_W:0]   coinSum;
    logic               chgLoad, chgStart, chgDone;
    logic [MONEY_W-1:0] chgValue, remaining;

    // Per-slot LEDs straight from the tables and current credit.
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        assign soldOut[i]   = (price[i] == '0) || (stock[i] == '0);
        assign canAfford[i] = !soldOut[i] && (credit >= price[i]);
    end

    // Event arbitration: cancel beats selection beats coin beats config.
    always_comb begin
        isIdle     = (state == ST_IDLE);
        selOk      = {1'b0, selIdx} < SLOTS;
        cfgOk      = {1'b0, cfgIdx} < SLOTS;
        coinSum    = {1'b0, credit} + (MONEY_W+1)'(coinValue(coinCode));
        refundGo   = isIdle && cancel && (credit != '0);
        vendGo     = isIdle && !cancel && selValid && selOk && !soldOut[selIdx]
                     && (credit >= price[selIdx]);
        showGo     = isIdle && !cancel && selValid && selOk && !soldOut[selIdx]
                     && (credit < price[selIdx]);
        coinAccept = isIdle && !cancel && !selValid && coinValid
                     && coinIsValid(coinCode) && (coinSum <= CEILING);
        cfgAccept  = isIdle && !cancel && !selValid && !coinValid && cfgWe
                     && cfgOk && (credit == '0);
        chgLoad    = refundGo || vendGo;
        chgValue   = refundGo ? credit : credit - price[selIdx];
        chgStart   = refundGo || ((state == ST_VEND) && (remaining != '0));
    end

    change_dispenser #(.MONEY_W(MONEY_W)) u_change (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (chgLoad),
        .loadValue (chgValue),
        .start     (chgStart),
        .remaining (remaining),
        .done      (chgDone),
        .chg       (chg)
    );

    // During a vend or payout the display tracks what is still owed.
    assign dispValue   = !isIdle ? remaining : (showPrice ? shownPrice : credit);
    assign dispIsPrice = showPrice;

    // Main FSM plus the credit, tables and registered strobes it owns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            credit     <= '0;
            price      <= '0;
            stock      <= '0;
            showPrice  <= 1'b0;
            shownPrice <= '0;
            coinReject <= 1'b0;
            vendValid  <= 1'b0;
            vendIdx    <= '0;
            busy       <= 1'b0;
        end else begin
            coinReject <= coinValid && !coinAccept;
            vendValid  <= vendGo;

            if (vendGo) begin
                vendIdx       <= selIdx;
                stock[selIdx] <= stock[selIdx] - STOCK_W'(1);
            end
            if (cfgAccept) begin
                price[cfgIdx] <= cfgPrice;
                stock[cfgIdx] <= cfgStock;
            end

            if (chgLoad)
                credit <= '0;
            else if (coinAccept)
                credit <= coinSum[MONEY_W-1:0];

            // A shown price persists until an accepted coin, cancel or vend.
            if ((isIdle && cancel) || vendGo || coinAccept) begin
                showPrice <= 1'b0;
            end else if (showGo) begin
                showPrice  <= 1'b1;
                shownPrice <= price[selIdx];
            end

            case (state)
                ST_IDLE: begin
                    if (refundGo) begin
                        state <= ST_CHANGE;
                        busy  <= 1'b1;
                    end else if (vendGo) begin
                        state <= ST_VEND;
                        busy  <= 1'b1;
                    end
                end
                ST_VEND: begin
                    if (remaining != '0) begin
                        state <= ST_CHANGE;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_CHANGE: begin
                    if (chgDone) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_vend_controller;

    localparam int NS = 9;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coinValid, selValid, cancel, cfgWe;
    logic [2:0] coinCode;
    logic [3:0] selIdx, cfgIdx;
    logic [7:0] cfgPrice;
    logic [3:0] cfgStock;
    logic [7:0] credit, dispValue;
    logic       dispIsPrice, coinReject, vendValid, busy;
    logic [NS-1:0] canAfford, soldOut;
    logic [3:0] vendIdx;

    vend_controller_if chgIf();

    vend_controller dut (
        .clk(clk), .rst_n(rst_n), .coinValid(coinValid), .coinCode(coinCode),
        .selValid(selValid), .selIdx(selIdx), .cancel(cancel), .cfgWe(cfgWe),
        .cfgIdx(cfgIdx), .cfgPrice(cfgPrice), .cfgStock(cfgStock),
        .credit(credit), .dispValue(dispValue), .dispIsPrice(dispIsPrice),
        .canAfford(canAfford), .soldOut(soldOut), .coinReject(coinReject),
        .vendValid(vendValid), .vendIdx(vendIdx), .busy(busy), .chg(chgIf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chkEn = 0;

    // Model: credit, tables, phase (0 idle, 1 vend, 2 paying) and the list
    // of change coins still to be handed out.
    int mCredit = 0;
    int mPrice[NS];
    int mStock[NS];
    int mPhase = 0;
    int mq[$];
    bit mShow = 0;
    int mShown = 0;
    bit mVend = 0, mReject = 0;
    int mVendIdx = 0;
    int coinVals[8] = '{1, 2, 5, 10, 20, 100, 0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Greedy change as a list of coin codes (3 dollar, 2 quarter, 1 dime, 0 nickel).
    function automatic void fillQueue(input int amt);
        int r = amt;
        mq.delete();
        while (r >= 20) begin mq.push_back(3); r -= 20; end
        while (r >= 5)  begin mq.push_back(2); r -= 5;  end
        while (r >= 2)  begin mq.push_back(1); r -= 2;  end
        while (r >= 1)  begin mq.push_back(0); r -= 1;  end
    endfunction

    function automatic int owed();
        int s = 0;
        int w[4] = '{1, 2, 5, 20};
        foreach (mq[i]) s += w[mq[i]];
        return s;
    endfunction

    task automatic modelStep();
        bit took = 0;
        int v;
        mVend = 0;
        mReject = 0;
        if (!rst_n) begin
            mCredit = 0; mPhase = 0; mShow = 0; mShown = 0; mq.delete();
            foreach (mPrice[i]) begin mPrice[i] = 0; mStock[i] = 0; end
            return;
        end
        case (mPhase)
            0: begin
                if (cancel) begin
                    mShow = 0;
                    if (mCredit != 0) begin fillQueue(mCredit); mCredit = 0; mPhase = 2; end
                end else if (selValid) begin
                    if (int'(selIdx) < NS && mPrice[selIdx] != 0 && mStock[selIdx] != 0) begin
                        if (mCredit < mPrice[selIdx]) begin
                            mShow = 1; mShown = mPrice[selIdx];
                        end else begin
                            fillQueue(mCredit - mPrice[selIdx]);
                            mCredit = 0; mStock[selIdx]--; mShow = 0;
                            mVend = 1; mVendIdx = int'(selIdx); mPhase = 1;
                        end
                    end
                end else if (coinValid) begin
                    v = coinVals[coinCode];
                    if (v > 0 && mCredit + v <= 100) begin mCredit += v; mShow = 0; took = 1; end
                end else if (cfgWe && mCredit == 0 && int'(cfgIdx) < NS) begin
                    mPrice[cfgIdx] = int'(cfgPrice); mStock[cfgIdx] = int'(cfgStock);
                end
            end
            1: mPhase = (mq.size() != 0) ? 2 : 0;
            default: begin
                if (chgIf.changeReady) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) mPhase = 0;
                end
            end
        endcase
        if (coinValid && !took) mReject = 1;
    endtask

    function automatic logic [NS-1:0] expSold();
        logic [NS-1:0] s;
        for (int i = 0; i < NS; i++) s[i] = (mPrice[i] == 0) || (mStock[i] == 0);
        return s;
    endfunction

    function automatic logic [NS-1:0] expAfford();
        logic [NS-1:0] a;
        for (int i = 0; i < NS; i++) a[i] = mPrice[i] != 0 && mStock[i] != 0 && mCredit >= mPrice[i];
        return a;
    endfunction

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk) begin
        if (chkEn) begin
            check("credit", credit, mCredit);
            check("busy", busy, mPhase != 0);
            check("vendValid", vendValid, mVend);
            if (mVend) check("vendIdx", vendIdx, mVendIdx);
            check("coinReject", coinReject, mReject);
            check("changeValid", chgIf.changeValid, mPhase == 2);
            if (mPhase == 2) check("changeCoin", chgIf.changeCoin, mq[0]);
            check("dispIsPrice", dispIsPrice, mShow);
            if (mPhase == 2) check("dispValue", dispValue, owed());
            else if (mPhase == 0) check("dispValue", dispValue, mShow ? mShown : mCredit);
            check("soldOut", soldOut, expSold());
            check("canAfford", canAfford, expAfford());
        end
    end

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        coinValid = 0; selValid = 0; cancel = 0; cfgWe = 0;
    endtask

    task automatic coin(input int code);
        coinValid = 1; coinCode = 3'(code); tick();
    endtask

    task automatic sel(input int idx);
        selValid = 1; selIdx = 4'(idx); tick();
    endtask

    task automatic cfg(input int idx, input int p, input int s);
        cfgWe = 1; cfgIdx = 4'(idx); cfgPrice = 8'(p); cfgStock = 4'(s); tick();
    endtask

    initial begin
        int n;
        rst_n = 0; coinValid = 0; selValid = 0; cancel = 0; cfgWe = 0;
        coinCode = 0; selIdx = 0; cfgIdx = 0; cfgPrice = 0; cfgStock = 0;
        chgIf.changeReady = 1;
        foreach (mPrice[i]) begin mPrice[i] = 0; mStock[i] = 0; end
        @(negedge clk);
        tick();
        chkEn = 1;
        tick();
        check("rst_credit", credit, 0);
        check("rst_soldOut", soldOut, 9'h1FF);
        check("rst_busy", busy, 0);
        check("rst_changeValid", chgIf.changeValid, 0);
        rst_n = 1;

        // Vend with one quarter of change.
        cfg(0, 20, 2);
        cfg(3, 35, 1);
        coin(4);
        coin(2);
        check("credit25", credit, 25);
        check("afford0", canAfford[0], 1);
        sel(0);
        check("vend0_valid", vendValid, 1);
        check("vend0_idx", vendIdx, 0);
        check("vend0_credit", credit, 0);
        check("model_stock0", mStock[0], 1);
        tick();
        check("chg_quarter", chgIf.changeCoin, 2);
        check("chg_valid", chgIf.changeValid, 1);
        tick();
        check("busy_done", busy, 0);

        // Price display, then a dime clears it.
        sel(3);
        check("price_disp", dispValue, 35);
        check("price_flag", dispIsPrice, 1);
        check("price_novend", vendValid, 0);
        coin(1);
        check("dime_credit", credit, 2);
        check("dime_flag", dispIsPrice, 0);

        // Stalled payout; coins offered meanwhile bounce.
        chgIf.changeReady = 0;
        cancel = 1; tick();
        for (int i = 0; i < 3; i++) begin
            coin(0);
            check("stall_reject", coinReject, 1);
            check("stall_coin", chgIf.changeCoin, 1);
            check("stall_remain", dispValue, 2);
        end
        chgIf.changeReady = 1;
        tick();
        check("stall_done", chgIf.changeValid, 0);

        // Ceiling, then a five-dollar refund as five dollar coins.
        coin(5);
        check("five_credit", credit, 100);
        coin(0);
        check("ceil_reject", coinReject, 1);
        check("ceil_credit", credit, 100);
        cancel = 1; tick();
        check("model_five_coins", mq.size(), 5);
        check("refund_coin", chgIf.changeCoin, 3);
        n = 0;
        while (chgIf.changeValid && n < 20) begin tick(); n++; end
        check("refund_cycles", n, 5);

        // Last item sells out; repeat selection ignored.
        coin(4); coin(3); coin(2);
        sel(3);
        check("vend3_idx", vendIdx, 3);
        tick();
        check("sold3", soldOut[3], 1);
        check("afford3", canAfford[3], 0);
        coin(1);
        sel(3);
        check("repeat_novend", vendValid, 0);
        check("repeat_flag", dispIsPrice, 0);

        // Simultaneous cancel/select/coin with credit 7, then reset mid-payout.
        coin(2);
        check("credit7", credit, 7);
        chgIf.changeReady = 0;
        cancel = 1; selValid = 1; selIdx = 0; coinValid = 1; coinCode = 0;
        tick();
        check("prio_reject", coinReject, 1);
        check("prio_novend", vendValid, 0);
        check("prio_chg", chgIf.changeValid, 1);
        rst_n = 0;
        tick();
        check("rst_mid_valid", chgIf.changeValid, 0);
        check("rst_mid_credit", credit, 0);
        rst_n = 1;

        // Random traffic.
        for (int i = 0; i < NS; i++) cfg(i, $urandom_range(1, 30), $urandom_range(1, 4));
        for (int c = 0; c < 3000; c++) begin
            coinValid = ($urandom_range(0, 99) < 30);
            coinCode  = 3'($urandom_range(0, 7));
            selValid  = ($urandom_range(0, 9) == 0);
            selIdx    = 4'($urandom_range(0, 10));
            cancel    = ($urandom_range(0, 24) == 0);
            cfgWe     = ($urandom_range(0, 7) == 0);
            cfgIdx    = 4'($urandom_range(0, 10));
            cfgPrice  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            cfgStock  = 4'($urandom_range(0, 3));
            chgIf.changeReady = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
# vend_controller

Clocked, parametrised vending-machine controller that replaces the edge-triggered selection/coin logic with a single synchronous FSM. It accumulates credit, keeps per-slot price and stock tables, and vends on selection. It returns change or refunds as a greedy coin stream over a valid/ready handshake. It sits between the debounced front-panel/coin-acceptor inputs and the display and dispenser drivers. All money is in nickel units (1 = $0.05).

## Interface
- `NUM_SLOTS`, 9: number of selectable slots (A1..C3 = 0..8).
- `MONEY_W`, 8: width of credit, price and change registers, in nickels.
- `MAX_CREDIT`, 100: credit ceiling in nickels ($5.00). Must satisfy `MAX_CREDIT + 100 < 2**MONEY_W`.
- `STOCK_W`, 4: per-slot stock counter width.
- `IDX_W`, `$clog2(NUM_SLOTS)`: derived slot-index width.
- Ports:
  - `clk`  in  1  system clock; all logic on the rising edge.
  - `rst_n`  in  1  synchronous, active-low reset.
  - `coinValid`  in  1  one-cycle strobe: coin or bill inserted.
  - `coinCode`  in  3  0 nickel, 1 dime, 2 quarter, 3 fifty, 4 dollar, 5 five; 6/7 invalid.
  - `selValid`  in  1  one-cycle strobe: slot button.
  - `selIdx`  in  IDX_W  selected slot.
  - `cancel`  in  1  one-cycle strobe: cancel/refund.
  - `cfgWe`  in  1  write price/stock for `cfgIdx`.
  - `cfgIdx`  in  IDX_W  slot to configure.
  - `cfgPrice`  in  MONEY_W  price in nickels; 0 = out of service.
  - `cfgStock`  in  STOCK_W  stock count.
  - `credit`  out  MONEY_W  current credit.
  - `dispValue`  out  MONEY_W  value for the 7-segment driver.
  - `dispIsPrice`  out  1  `dispValue` is a price, not credit/change.
  - `canAfford`  out  NUM_SLOTS  green LEDs: `credit >= price`, price != 0, stock != 0.
  - `soldOut`  out  NUM_SLOTS  red LEDs: price == 0 or stock == 0.
  - `coinReject`  out  1  one-cycle pulse: the coin was returned.
  - `vendValid`  out  1  one-cycle pulse: dispense `vendIdx`.
  - `vendIdx`  out  IDX_W  slot being vended.
  - `changeValid`  out  1  change coin offered.
  - `changeCoin`  out  2  0 nickel, 1 dime, 2 quarter, 3 dollar.
  - `changeReady`  in  1  dispenser accepts coin.
  - `busy`  out  1  FSM is in VEND or CHANGE.

## Operation
- FSM states: IDLE, VEND, CHANGE.
- Event priority per cycle: `cancel` > `selValid` > `coinValid` > `cfgWe`. A losing coin pulses `coinReject`. A losing selection or config write is dropped.
- **Coin handling (IDLE).**
  - Coin values in nickels: 1, 2, 5, 10, 20, 100.
  - If `credit + value > MAX_CREDIT` or the code is 6/7: `coinReject` pulses and credit is unchanged.
  - Otherwise credit += value.
  - In VEND/CHANGE every coin is rejected.
- **Selection (IDLE).**
  - Slot is sold out, or `selIdx >= NUM_SLOTS`: ignored, display unchanged.
  - `credit == 0`, or `credit < price`: display shows the price, `dispIsPrice=1`, state unchanged.
  - Otherwise go to VEND: `remaining = credit - price`, credit cleared, stock decremented.
- **VEND.** Lasts one cycle, with `vendValid=1`. Then CHANGE if `remaining != 0`, else IDLE.
- **Cancel.**
  - In IDLE with credit != 0: `remaining = credit`, credit cleared, go to CHANGE.
  - With credit 0 it only clears a shown price.
  - Ignored in VEND/CHANGE.
- **CHANGE.** Greedy coin selection: dollar (20), then quarter (5), then dime (2), then nickel (1).
  - `changeCoin` is the largest coin not exceeding `remaining`, held stable while `changeValid && !changeReady`.
  - On the handshake, `remaining` is reduced by that coin's value.
  - When `remaining` reaches 0, go to IDLE.
- **Config (IDLE only, credit 0).** Writes the price/stock entry. Ignored otherwise or when `cfgIdx >= NUM_SLOTS`.
- **Display.**
  - IDLE: credit, unless a price is being shown.
  - A price stays shown until the next accepted coin, cancel, or vend.
  - CHANGE: `remaining`.
- **Reset.** All prices, stock, credit and `remaining` go to 0. State IDLE. All strobes, `changeValid` and `busy` are 0; `soldOut` is all-ones. Reset mid-CHANGE aborts the change immediately.

## Timing
- Coin at edge t → `credit`/`coinReject` valid after edge t+1.
- Selection at t → `vendValid` high for cycle t+1. Stock decrement and credit clear are visible at the same time.
- `changeValid` first asserts in cycle t+2 when change is owed. `busy` deasserts the cycle after the last handshake.
- One coin is accepted per cycle when `changeReady` is held high. Zero-wait: N coins take N cycles.
- `canAfford`/`soldOut` are registered-input combinational: they reflect the tables and credit in the same cycle.

## Structure
- Package `vend_pkg`:
  - coin-code enum
  - coin value constants in nickels
  - change-coin enum and values
  - FSM state enum
- Sub-module `change_dispenser`: holds `remaining`, does the greedy selection and drives the valid/ready port. It is loaded by the top FSM and returns `done`.

## Test plan
- Reset, config slot 0 = 20/stock 2, dollar + quarter (credit 25), select 0 → `vendValid`, `vendIdx=0`, stock 1, one quarter returned, IDLE.
- With credit 0, select slot 3 (price 35) → `dispValue=35`, `dispIsPrice=1`, no vend. Then a dime → credit 2, `dispIsPrice=0`.
- Five (100), then a nickel at `MAX_CREDIT=100` → `coinReject` pulse, credit stays 100. Cancel → five dollar coins over the handshake.
- `changeReady` held low 3 cycles mid-CHANGE → `changeCoin` stable, `remaining` unchanged. Coins inserted meanwhile are all rejected.
- Slot with stock 1 vended → `soldOut` bit set, `canAfford` bit clear. A repeat selection is ignored.
- `cancel`, `selValid` and `coinValid` in the same cycle with credit 7 → refund path, `coinReject`, no vend. Assert `rst_n=0` mid-CHANGE → `changeValid=0` next cycle and `credit=0`.
